core_seq_ctrl: RTL
==================

Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue core. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Owns the instruction register that feeds decode.
- Handshakes with the instruction and data memory ports.
- Gates the write enables for the PC, register file and CSR file.
- Traps on illegal opcodes or on memory ports that stop responding.

Parameters:
- MEM_TIMEOUT, 8'd255: cycles a memory request may wait for ack before a bus-error trap. Legal range 1..255.
- NOP_INSN, 32'h0000_0013: ir value at reset (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  synchronous reset, active low.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch done; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- ir  out  32  instruction register, drives decode code input.
- wb_reg  in  1  register writeback request from decode.
- wb_csr  in  1  CSR writeback request from decode.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_ack  in  1  data access done; load data valid this cycle.
- ld_we  out  1  latch load data into the load-data register.
- pc_we  out  1  commit next PC (the PC mux is selected by decode's pc_sel).
- reg_we  out  1  register file write enable.
- csr_we  out  1  CSR file write enable.
- state  out  3  current state, for debug.
- trap  out  1  sticky: core halted.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 imem timeout, 11 dmem timeout.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at a clock edge), regardless of state or pending memory transaction:
  - state=FETCH, ir=NOP_INSN, trap=0, trap_cause=00, instret=0, timeout counter=0.
  - Every request and enable output is 0 in the reset cycle.
  - A pending ack arriving later is ignored.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP with cause 01.
- Outputs:
  - All outputs are Moore, decoded from registered state, except ld_we = (state==MEM) & ~dmem_we & dmem_ack.
  - ir, trap, trap_cause and instret are registers.
- FETCH:
  - imem_req=1 in every FETCH cycle.
  - On imem_ack=1: ir<=imem_rdata, go to DECODE.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 without ack: go to TRAP, cause 10.
  - If ack and the timeout fall in the same cycle, ack wins.
- DECODE (1 cycle):
  - Legal when ir[1:0]==2'b11 and ir[6:2] ∈ {01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR, 11000 BRANCH, 00000 LOAD, 01000 STORE, 00100 OP-IMM, 01100 OP, 00011 MISC-MEM, 11100 SYSTEM}.
  - MISC-MEM executes as a NOP.
  - Legal → EXEC. Illegal → TRAP, cause 01.
- EXEC (1 cycle): go to MEM if ir[6:0] is LOAD or STORE, else WB.
- MEM:
  - dmem_req=1, dmem_we = (ir[6:0]==7'b0100011).
  - On dmem_ack: go to WB.
  - Timeout rule is the same as FETCH; a timeout goes to TRAP with cause 11.
- Timeout counter: cleared on every state entry.
- WB (1 cycle):
  - pc_we=1, reg_we=wb_reg, csr_we=wb_csr.
  - instret<=instret+1, wrapping modulo 2^32.
  - Go to FETCH.
  - Stores and branches never assert reg_we, because decode drives wb_reg=0 for them.
- TRAP:
  - Absorbing state; all enables and requests are 0.
  - trap=1 and trap_cause are held until reset.
  - First-cause-wins: trap_cause is written only on entry.
- Latency with zero-wait ack (imem_ack in the first FETCH cycle):
  - ALU/branch/jump: 4 cycles.
  - Load/store with dmem_ack in the first MEM cycle: 5 cycles.
  - Each wait cycle adds 1.
- An ack arriving while the corresponding request is 0 is ignored.
- dmem_req and imem_req are never asserted in the same cycle.

Test Plan:
- addi x1,x0,5 (32'h00500093), imem_ack in the first FETCH cycle → states 0,1,2,4,0. reg_we=1 and pc_we=1 only in the WB cycle. instret=1.
- lw x2,0(x1) (32'h0000A103), dmem_ack after 3 wait cycles → dmem_req=1 and dmem_we=0 for 4 cycles. ld_we pulses once, coincident with ack. WB reg_we=1. Total 8 cycles.
- sw x2,4(x1) (32'h0020A223), immediate ack → dmem_we=1 in MEM. WB has reg_we=0, pc_we=1. instret increments.
- ir=32'hFFFFFFFF → DECODE goes to TRAP. trap=1, trap_cause=01. No pc_we/reg_we ever asserted. state stays 5 for 100 cycles.
- MEM_TIMEOUT=4, imem_ack held 0 → TRAP after 4 FETCH cycles, cause 10. Repeat with ack on cycle 4 → DECODE, no trap.
- Assert rst_n=0 mid-MEM with dmem_req=1 → next cycle state=FETCH, dmem_req=0, ir=32'h00000013, instret=0. A late dmem_ack is ignored.

Source files
------------

// File: rtl/core_seq_ctrl_if.sv
// Memory handshake bundle between the core sequencer and the instruction /
// data memory ports.
//   imem_req   : instruction fetch request (sequencer -> memory)
//   imem_ack   : fetch done, imem_rdata valid this cycle (memory -> sequencer)
//   imem_rdata : fetched instruction word (memory -> sequencer)
//   dmem_req   : data access request (sequencer -> memory)
//   dmem_we    : 1 = store, 0 = load, valid while dmem_req=1
//   dmem_ack   : data access done, load data valid this cycle
interface core_seq_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue core. Steps every instruction
// through FETCH, DECODE, EXEC, (MEM,) WB; owns the instruction register,
// gates the PC / register-file / CSR write enables and halts on illegal
// opcodes or memory ports that stop answering.
//
// Ports:
//   clk, rst_n          : core clock, synchronous active-low reset
//   bus (master)        : instruction / data memory handshake
//   ir                  : instruction register feeding decode
//   wb_reg, wb_csr      : writeback requests from decode
//   ld_we               : latch load data (load ack in MEM)
//   pc_we, reg_we, csr_we : commit enables, only in WB
//   state               : current state (debug)
//   trap, trap_cause    : sticky halt flag and its first cause
//   instret             : retired-instruction count
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | imem_req high, wait for imem_ack or timeout
// DECODE | one cycle, check opcode legality
// EXEC   | one cycle, choose MEM (load/store) or WB
// MEM    | dmem_req high, wait for dmem_ack or timeout
// WB     | one cycle, commit PC / reg / CSR, count retirement
// TRAP   | absorbing halt until reset
module core_seq_ctrl #(
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255,
    parameter logic [31:0] NOP_INSN    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    core_seq_ctrl_if.master       bus,
    output logic [31:0]           ir,
    input  logic                  wb_reg,
    input  logic                  wb_csr,
    output logic                  ld_we,
    output logic                  pc_we,
    output logic                  reg_we,
    output logic                  csr_we,
    output logic [2:0]            state,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [31:0]           instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    state_t     st;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       op_legal;
    logic       is_mem;
    logic       is_store;

    // Last permitted waiting cycle: counter starts at 0 on state entry, so a
    // request gets exactly MEM_TIMEOUT cycles before the trap.
    assign tmo_hit  = (tmo_cnt == (MEM_TIMEOUT - 8'd1));
    assign is_store = (ir[6:0] == OPC_STORE);
    assign is_mem   = (ir[6:0] == OPC_LOAD) || is_store;

    always_comb begin
        op_legal = 1'b0;
        if (ir[1:0] == 2'b11) begin
            case (ir[6:2])
                5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b00011,
                5'b11100: op_legal = 1'b1;
                default:  op_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= S_FETCH;
            ir         <= NOP_INSN;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
            instret    <= 32'd0;
            tmo_cnt    <= 8'd0;
        end else begin
            case (st)
                S_FETCH: begin
                    // ack takes priority over a coincident timeout
                    if (bus.imem_ack) begin
                        ir      <= bus.imem_rdata;
                        st      <= S_DECODE;
                        tmo_cnt <= 8'd0;
                    end else if (tmo_hit) begin
                        st         <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                        tmo_cnt    <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    tmo_cnt <= 8'd0;
                    if (op_legal) begin
                        st <= S_EXEC;
                    end else begin
                        st         <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                    end
                end
                S_EXEC: begin
                    tmo_cnt <= 8'd0;
                    st      <= is_mem ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        st      <= S_WB;
                        tmo_cnt <= 8'd0;
                    end else if (tmo_hit) begin
                        st         <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'b11;
                        tmo_cnt    <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    tmo_cnt <= 8'd0;
                    instret <= instret + 32'd1;
                    st      <= S_FETCH;
                end
                S_TRAP: begin
                    tmo_cnt <= 8'd0;
                end
                default: begin
                    // codes 6/7 are unreachable; treat them as illegal
                    tmo_cnt    <= 8'd0;
                    st         <= S_TRAP;
                    trap       <= 1'b1;
                    trap_cause <= 2'b01;
                end
            endcase
        end
    end

    // Moore decode of the state register; rst_n masks every request and
    // enable so nothing fires in the reset cycle itself.
    assign state        = st;
    assign bus.imem_req = rst_n && (st == S_FETCH);
    assign bus.dmem_req = rst_n && (st == S_MEM);
    assign bus.dmem_we  = bus.dmem_req && is_store;
    assign ld_we        = bus.dmem_req && !is_store && bus.dmem_ack;
    assign pc_we        = rst_n && (st == S_WB);
    assign reg_we       = pc_we && wb_reg;
    assign csr_we       = pc_we && wb_csr;

endmodule
